instr_fetch: RTL and testbench

Fetch stage that produces the instruction stream consumed by instr_decode. Holds the PC and issues word reads to instruction memory over a valid/ready request channel with a valid-only response channel. Buffers returned words with their PC in a small FIFO and presents them to decode over a valid/ready handshake. Supports halt and branch/jump redirect with flush of stale fetches.

---
 rtl/instr_fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/instr_fetch.sv | 118 +++++++++++
 tb/tb_instr_fetch.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package instr_fetch_pkg;

   localparam int          XLEN_DEF     = 32;
   localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
   localparam int          INSTR_W      = 32;
   localparam int          PC_INC       = 4;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_WAIT  = 2'd1,
      ST_DRAIN = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer: registered storage, combinational head read, synchronous flush.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic [WIDTH-1:0]         head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: single-outstanding imem reads, PC-tagged buffer to decode, halt and redirect/flush.
// Optional FETCH_PERF_CNT_EN adds fetched-instruction and redirect counters.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter int             XLEN       = XLEN_DEF,
   parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEF),
   parameter int             FIFO_DEPTH = 2
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_halt,
   input  logic            i_redirect_valid,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_imem_req_valid,
   output logic [XLEN-1:0] o_imem_req_addr,
   input  logic            i_imem_req_ready,
   input  logic            i_imem_rsp_valid,
   input  logic [XLEN-1:0] i_imem_rsp_data,
   output logic            o_instr_valid,
   output logic [XLEN-1:0] o_instr,
   output logic [XLEN-1:0] o_instr_pc,
   input  logic            i_instr_ready
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     o_fetch_cnt,
   output logic [31:0]     o_flush_cnt
`endif
);

   // state    | meaning
   // ST_FETCH | no request outstanding; issue at pc when not halted and a slot is free
   // ST_WAIT  | request accepted; next response is pushed with req_pc
   // ST_DRAIN | request outstanding on a flushed path; next response is dropped

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e     state;
   logic [XLEN-1:0]  pc;
   logic [XLEN-1:0]  req_pc;
   logic [XLEN-1:0]  redirect_tgt;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_empty;
   logic [2*XLEN-1:0] fifo_head;
   logic             req_fire;
   logic             rsp_push;
   logic             instr_pop;
   logic             outstanding_next;

   assign redirect_tgt     = i_redirect_pc & ~XLEN'(3);
   // No request is outstanding in FETCH, so count alone bounds buffer occupancy.
   assign o_imem_req_valid = !i_rst && (state == ST_FETCH) && !i_halt &&
                             (fifo_count < CNT_W'(FIFO_DEPTH));
   assign o_imem_req_addr  = pc;
   assign req_fire         = o_imem_req_valid && i_imem_req_ready;
   assign rsp_push         = (state == ST_WAIT) && i_imem_rsp_valid && !i_redirect_valid;
   assign instr_pop        = o_instr_valid && i_instr_ready;
   assign outstanding_next = req_fire || ((state != ST_FETCH) && !i_imem_rsp_valid);

   assign o_instr_valid = !fifo_empty;
   assign o_instr       = fifo_head[XLEN-1:0];
   assign o_instr_pc    = fifo_head[2*XLEN-1:XLEN];

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state  <= ST_FETCH;
         pc     <= RESET_PC;
         req_pc <= RESET_PC;
      end else if (i_redirect_valid) begin
         pc    <= redirect_tgt;
         state <= outstanding_next ? ST_DRAIN : ST_FETCH;
      end else begin
         case (state)
            ST_FETCH: begin
               if (req_fire) begin
                  req_pc <= pc;
                  pc     <= pc + XLEN'(PC_INC);
                  state  <= ST_WAIT;
               end
            end
            ST_WAIT, ST_DRAIN: begin
               if (i_imem_rsp_valid) begin
                  state <= ST_FETCH;
               end
            end
            default: state <= ST_FETCH;
         endcase
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (2*XLEN)
   ) u_fifo (
      .clk       (i_clk),
      .rst       (i_rst),
      .flush     (i_redirect_valid),
      .push      (rsp_push),
      .push_data ({req_pc, i_imem_rsp_data}),
      .pop       (instr_pop),
      .count     (fifo_count),
      .empty     (fifo_empty),
      .head      (fifo_head)
   );

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_fetch_cnt <= '0;
         o_flush_cnt <= '0;
      end else begin
         if (instr_pop) o_fetch_cnt <= o_fetch_cnt + 32'd1;
         if (i_redirect_valid) o_flush_cnt <= o_flush_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: memory model returns ~addr after a programmable latency.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        halt;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [31:0] flush_cnt;
`endif

   int vec = 0;
   int miscmp = 0;
   int lat = 1;
   int cd = 0;
   logic [31:0] paddr;
   logic [31:0] req_q[$];
   logic [31:0] dpc_q[$];
   logic [31:0] dins_q[$];

   always #5 clk = ~clk;

   instr_fetch dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_halt           (halt),
      .i_redirect_valid (redirect_valid),
      .i_redirect_pc    (redirect_pc),
      .o_imem_req_valid (imem_req_valid),
      .o_imem_req_addr  (imem_req_addr),
      .i_imem_req_ready (imem_req_ready),
      .i_imem_rsp_valid (imem_rsp_valid),
      .i_imem_rsp_data  (imem_rsp_data),
      .o_instr_valid    (instr_valid),
      .o_instr          (instr),
      .o_instr_pc       (instr_pc),
      .i_instr_ready    (instr_ready)
`ifdef FETCH_PERF_CNT_EN
      ,
      .o_fetch_cnt      (fetch_cnt),
      .o_flush_cnt      (flush_cnt)
`endif
   );

   // Memory model: response visible 'lat' edges after the accepting edge.
   always @(posedge clk) begin
      logic        acc;
      logic [31:0] a;
      acc = imem_req_valid && imem_req_ready && !rst;
      a   = imem_req_addr;
      #1;
      imem_rsp_valid = 1'b0;
      if (acc) begin
         paddr = a;
         cd    = lat;
      end
      if (cd > 0) begin
         cd = cd - 1;
         if (cd == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~paddr;
         end
      end
   end

   always @(posedge clk) begin
      if (!rst) begin
         if (imem_req_valid && imem_req_ready) req_q.push_back(imem_req_addr);
         if (instr_valid && instr_ready) begin
            dpc_q.push_back(instr_pc);
            dins_q.push_back(instr);
         end
      end
   end

   function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
      return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
   endfunction

   task automatic clear_logs();
      req_q.delete();
      dpc_q.delete();
      dins_q.delete();
   endtask

   // Called at a negedge; returns at the negedge after the redirect edge.
   task automatic restart(input logic [31:0] tgt);
      redirect_valid = 1'b1;
      redirect_pc    = tgt;
      @(negedge clk);
      redirect_valid = 1'b0;
      clear_logs();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      vec++; if (imem_req_valid !== 1'b0) begin miscmp++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
      vec++; if (instr_valid !== 1'b0) begin miscmp++; $display("FAIL rst_instr_valid: got %b want 0", instr_valid); end
      vec++; if (imem_req_addr !== 32'h0) begin miscmp++; $display("FAIL rst_req_addr: got %h want 00000000", imem_req_addr); end
      vec++; if (instr !== 32'h0) begin miscmp++; $display("FAIL rst_instr: got %h want 00000000", instr); end
      vec++; if (instr_pc !== 32'h0) begin miscmp++; $display("FAIL rst_instr_pc: got %h want 00000000", instr_pc); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_stream();
      logic [31:0] exp_pc [3];
      exp_pc = '{32'h0, 32'h4, 32'h8};
      for (int i = 0; i < 30 && dpc_q.size() < 3; i++) @(negedge clk);
      vec++; if (dpc_q.size() < 3) begin miscmp++; $display("FAIL stream_count: got %0d want 3", dpc_q.size()); end
      for (int i = 0; i < 3; i++) begin
         vec++; if (at(req_q, i) !== exp_pc[i]) begin miscmp++; $display("FAIL stream_req[%0d]: got %h want %h", i, at(req_q, i), exp_pc[i]); end
         vec++; if (at(dpc_q, i) !== exp_pc[i]) begin miscmp++; $display("FAIL stream_pc[%0d]: got %h want %h", i, at(dpc_q, i), exp_pc[i]); end
         vec++; if (at(dins_q, i) !== ~exp_pc[i]) begin miscmp++; $display("FAIL stream_instr[%0d]: got %h want %h", i, at(dins_q, i), ~exp_pc[i]); end
      end
   endtask

   task automatic test_backpressure();
      instr_ready = 1'b0;
      restart(32'h0);
      repeat (10) @(negedge clk);
      vec++; if (req_q.size() != 2) begin miscmp++; $display("FAIL bp_buffered: got %0d want 2", req_q.size()); end
      vec++; if (imem_req_valid !== 1'b0) begin miscmp++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
      vec++; if (instr_valid !== 1'b1) begin miscmp++; $display("FAIL bp_instr_valid: got %b want 1", instr_valid); end
      vec++; if (instr_pc !== 32'h0) begin miscmp++; $display("FAIL bp_head_pc: got %h want 00000000", instr_pc); end
      vec++; if (instr !== 32'hFFFF_FFFF) begin miscmp++; $display("FAIL bp_head_instr: got %h want ffffffff", instr); end
      instr_ready = 1'b1;
      for (int i = 0; i < 30 && dpc_q.size() < 3; i++) @(negedge clk);
      vec++; if (at(dpc_q, 0) !== 32'h0) begin miscmp++; $display("FAIL bp_pc0: got %h want 00000000", at(dpc_q, 0)); end
      vec++; if (at(dpc_q, 1) !== 32'h4) begin miscmp++; $display("FAIL bp_pc1: got %h want 00000004", at(dpc_q, 1)); end
      vec++; if (at(dpc_q, 2) !== 32'h8) begin miscmp++; $display("FAIL bp_pc2: got %h want 00000008", at(dpc_q, 2)); end
      vec++; if (at(req_q, 2) !== 32'h8) begin miscmp++; $display("FAIL bp_resume_req: got %h want 00000008", at(req_q, 2)); end
   endtask

   task automatic test_redirect_wait();
      lat = 3;
      restart(32'h40);
      for (int i = 0; i < 20 && req_q.size() < 1; i++) @(negedge clk);
      vec++; if (at(req_q, 0) !== 32'h40) begin miscmp++; $display("FAIL rdw_first_req: got %h want 00000040", at(req_q, 0)); end
      restart(32'h103);
      vec++; if (imem_req_valid !== 1'b0) begin miscmp++; $display("FAIL rdw_drain_req_valid: got %b want 0", imem_req_valid); end
      vec++; if (imem_req_addr !== 32'h100) begin miscmp++; $display("FAIL rdw_addr: got %h want 00000100", imem_req_addr); end
      vec++; if (instr_valid !== 1'b0) begin miscmp++; $display("FAIL rdw_fifo_empty: got %b want 0", instr_valid); end
      for (int i = 0; i < 30 && dpc_q.size() < 1; i++) @(negedge clk);
      vec++; if (at(dpc_q, 0) !== 32'h100) begin miscmp++; $display("FAIL rdw_deliver_pc: got %h want 00000100", at(dpc_q, 0)); end
      vec++; if (at(dins_q, 0) !== 32'hFFFF_FEFF) begin miscmp++; $display("FAIL rdw_deliver_instr: got %h want fffffeff", at(dins_q, 0)); end
      vec++; if (at(req_q, 0) !== 32'h100) begin miscmp++; $display("FAIL rdw_next_req: got %h want 00000100", at(req_q, 0)); end
      lat = 1;
   endtask

   task automatic test_halt();
      restart(32'h300);
      for (int i = 0; i < 20 && req_q.size() < 2; i++) @(negedge clk);
      halt = 1'b1;
      repeat (6) @(negedge clk);
      vec++; if (req_q.size() != 2) begin miscmp++; $display("FAIL halt_req_count: got %0d want 2", req_q.size()); end
      vec++; if (imem_req_valid !== 1'b0) begin miscmp++; $display("FAIL halt_req_valid: got %b want 0", imem_req_valid); end
      vec++; if (dpc_q.size() != 2) begin miscmp++; $display("FAIL halt_delivered: got %0d want 2", dpc_q.size()); end
      vec++; if (at(dpc_q, 1) !== 32'h304) begin miscmp++; $display("FAIL halt_last_pc: got %h want 00000304", at(dpc_q, 1)); end
      halt = 1'b0;
      for (int i = 0; i < 20 && dpc_q.size() < 3; i++) @(negedge clk);
      vec++; if (at(req_q, 2) !== 32'h308) begin miscmp++; $display("FAIL halt_resume_req: got %h want 00000308", at(req_q, 2)); end
      vec++; if (at(dpc_q, 2) !== 32'h308) begin miscmp++; $display("FAIL halt_resume_pc: got %h want 00000308", at(dpc_q, 2)); end
   endtask

   task automatic test_req_stall();
      imem_req_ready = 1'b0;
      restart(32'h500);
      for (int i = 0; i < 10 && !imem_req_valid; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         vec++; if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h500}) begin
            miscmp++; $display("FAIL stall_hold[%0d]: got %b/%h want 1/00000500", i, imem_req_valid, imem_req_addr);
         end
         @(negedge clk);
      end
      vec++; if (req_q.size() != 0) begin miscmp++; $display("FAIL stall_no_accept: got %0d want 0", req_q.size()); end
      imem_req_ready = 1'b1;
      @(negedge clk);
      vec++; if (at(req_q, 0) !== 32'h500) begin miscmp++; $display("FAIL stall_accept: got %h want 00000500", at(req_q, 0)); end
      for (int i = 0; i < 20 && dpc_q.size() < 1; i++) @(negedge clk);
      vec++; if (at(dpc_q, 0) !== 32'h500) begin miscmp++; $display("FAIL stall_deliver: got %h want 00000500", at(dpc_q, 0)); end
   endtask

   task automatic test_wrap();
      restart(32'hFFFF_FFFC);
      for (int i = 0; i < 30 && dpc_q.size() < 2; i++) @(negedge clk);
      vec++; if (at(req_q, 1) !== 32'h0) begin miscmp++; $display("FAIL wrap_req1: got %h want 00000000", at(req_q, 1)); end
      vec++; if (at(dpc_q, 0) !== 32'hFFFF_FFFC) begin miscmp++; $display("FAIL wrap_pc0: got %h want fffffffc", at(dpc_q, 0)); end
      vec++; if (at(dins_q, 0) !== 32'h3) begin miscmp++; $display("FAIL wrap_instr0: got %h want 00000003", at(dins_q, 0)); end
      vec++; if (at(dpc_q, 1) !== 32'h0) begin miscmp++; $display("FAIL wrap_pc1: got %h want 00000000", at(dpc_q, 1)); end
      vec++; if (at(dins_q, 1) !== 32'hFFFF_FFFF) begin miscmp++; $display("FAIL wrap_instr1: got %h want ffffffff", at(dins_q, 1)); end
   endtask

   initial begin
      rst            = 1'b1;
      halt           = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      instr_ready    = 1'b1;
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_wait();
      test_halt();
      test_req_stall();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
